// File: rtl/game_draw_engine.sv
// game_draw_engine: raster engine for a 160x120 VGA frame buffer.
// Scans one command region per pixel per cycle; latches bird/wall collisions.
module game_draw_engine (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  input  logic [6:0] bird_y,
  input  logic [7:0] wall_x,
  input  logic [6:0] gap_y,
  output logic       cmd_ready,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       flag,
  output logic       touched
);

  localparam logic [2:0] OP_CLEAR = 3'd0;
  localparam logic [2:0] OP_DBIRD = 3'd1;
  localparam logic [2:0] OP_EBIRD = 3'd2;
  localparam logic [2:0] OP_DWALL = 3'd3;
  localparam logic [2:0] OP_EWALL = 3'd4;
  localparam logic [2:0] OP_CHECK = 3'd5;

  localparam logic [8:0] X_MAX   = 9'd159;
  localparam logic [7:0] Y_MAX   = 8'd119;
  localparam logic [8:0] BIRD_X0 = 9'd40;
  localparam logic [8:0] BIRD_X1 = 9'd43;
  localparam logic [7:0] BIRD_H1 = 8'd3;
  localparam logic [8:0] WALL_W1 = 9'd7;
  localparam logic [7:0] GAP_H   = 8'd32;

  localparam logic [2:0] C_BIRD  = 3'b110;
  localparam logic [2:0] C_WALL  = 3'b010;
  localparam logic [2:0] C_BLANK = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  function automatic logic f_is_bird(
    input logic [2:0] op
  );
    return (op == OP_DBIRD) || (op == OP_EBIRD);
  endfunction

  function automatic logic f_is_wall(
    input logic [2:0] op
  );
    return (op == OP_DWALL) || (op == OP_EWALL);
  endfunction

  // Region origin column (9 bits so wall_x+7 never wraps).
  function automatic logic [8:0] f_x0(
    input logic [2:0] op,
    input logic [7:0] wx
  );
    logic [8:0] v;
    unique case (1'b1)
      f_is_bird(op): v = BIRD_X0;
      f_is_wall(op): v = {1'b0, wx};
      default:       v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [8:0] f_x1(
    input logic [2:0] op,
    input logic [7:0] wx
  );
    logic [8:0] v;
    unique case (1'b1)
      (op == OP_CLEAR): v = X_MAX;
      f_is_bird(op):    v = BIRD_X1;
      f_is_wall(op):    v = {1'b0, wx} + WALL_W1;
      default:          v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] f_y0(
    input logic [2:0] op,
    input logic [6:0] by
  );
    logic [7:0] v;
    v = f_is_bird(op) ? {1'b0, by} : 8'd0;
    return v;
  endfunction

  function automatic logic [7:0] f_y1(
    input logic [2:0] op,
    input logic [6:0] by
  );
    logic [7:0] v;
    unique case (1'b1)
      (op == OP_CLEAR): v = Y_MAX;
      f_is_bird(op):    v = {1'b0, by} + BIRD_H1;
      f_is_wall(op):    v = Y_MAX;
      default:          v = '0;
    endcase
    return v;
  endfunction

  // Off-screen pixels and wall-gap rows consume a cycle but never write.
  function automatic logic f_plot(
    input logic [2:0] op,
    input logic [8:0] px,
    input logic [7:0] py,
    input logic [6:0] gy
  );
    logic draws;
    logic on_scr;
    logic in_gap;
    draws  = (op <= OP_EWALL);
    on_scr = (px <= X_MAX) && (py <= Y_MAX);
    in_gap = f_is_wall(op)
          && (py >= {1'b0, gy})
          && (py < ({1'b0, gy} + GAP_H));
    return draws && on_scr && !in_gap;
  endfunction

  function automatic logic [2:0] f_colour(
    input logic [2:0] op
  );
    logic [2:0] v;
    unique case (1'b1)
      (op == OP_DBIRD): v = C_BIRD;
      (op == OP_DWALL): v = C_WALL;
      default:          v = C_BLANK;
    endcase
    return v;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;

  logic [2:0] r_op;
  logic [6:0] r_bird_y;
  logic [7:0] r_wall_x;
  logic [6:0] r_gap_y;
  logic [8:0] r_px;
  logic [7:0] r_py;
  logic       r_plot;
  logic [2:0] r_colour;
  logic       r_touched;

  logic [8:0] w_px_nxt;
  logic [7:0] w_py_nxt;
  logic       w_plot_nxt;
  logic [2:0] w_colour_nxt;
  logic       w_load;
  logic       w_touch_en;

  logic [8:0] w_sx;
  logic [7:0] w_sy;
  logic [8:0] w_x0;
  logic [8:0] w_x1;
  logic [7:0] w_y1;
  logic       w_row_end;
  logic       w_last;
  logic [8:0] w_adv_px;
  logic [7:0] w_adv_py;

  logic [8:0] w_wx0;
  logic [8:0] w_wx1;
  logic [7:0] w_by0;
  logic [7:0] w_by1;
  logic [7:0] w_gy0;
  logic [7:0] w_gy1;
  logic       w_overlap;
  logic       w_hit;

  assign w_sx      = f_x0(cmd_op, wall_x);
  assign w_sy      = f_y0(cmd_op, bird_y);
  assign w_x0      = f_x0(r_op, r_wall_x);
  assign w_x1      = f_x1(r_op, r_wall_x);
  assign w_y1      = f_y1(r_op, r_bird_y);
  assign w_row_end = (r_px == w_x1);
  assign w_last    = (r_op >= OP_CHECK)
                  || (w_row_end && (r_py == w_y1));
  assign w_adv_px  = w_row_end ? w_x0 : r_px + 9'd1;
  assign w_adv_py  = w_row_end ? r_py + 8'd1 : r_py;

  assign w_wx0     = {1'b0, r_wall_x};
  assign w_wx1     = w_wx0 + WALL_W1;
  assign w_by0     = {1'b0, r_bird_y};
  assign w_by1     = w_by0 + BIRD_H1;
  assign w_gy0     = {1'b0, r_gap_y};
  assign w_gy1     = w_gy0 + GAP_H;
  assign w_overlap = (w_wx0 <= BIRD_X1) && (w_wx1 >= BIRD_X0);
  assign w_hit     = (w_overlap && ((w_by0 < w_gy0) || (w_by1 >= w_gy1)))
                  || (w_by1 > Y_MAX);

  // Next state plus the pixel to present in the following cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_px_nxt     = r_px;
    w_py_nxt     = r_py;
    w_plot_nxt   = 1'b0;
    w_colour_nxt = r_colour;
    w_load       = 1'b0;
    w_touch_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt  = S_RUN;
          w_load       = 1'b1;
          w_px_nxt     = w_sx;
          w_py_nxt     = w_sy;
          w_plot_nxt   = f_plot(cmd_op, w_sx, w_sy, gap_y);
          w_colour_nxt = f_colour(cmd_op);
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
          w_touch_en  = (r_op == OP_CHECK);
        end else begin
          w_px_nxt   = w_adv_px;
          w_py_nxt   = w_adv_py;
          w_plot_nxt = f_plot(r_op, w_adv_px, w_adv_py, r_gap_y);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command latch, scan position, registered pixel outputs, collision flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= '0;
      r_bird_y  <= '0;
      r_wall_x  <= '0;
      r_gap_y   <= '0;
      r_px      <= '0;
      r_py      <= '0;
      r_plot    <= 1'b0;
      r_colour  <= '0;
      r_touched <= 1'b0;
    end else begin
      if (w_load) begin
        r_op     <= cmd_op;
        r_bird_y <= bird_y;
        r_wall_x <= wall_x;
        r_gap_y  <= gap_y;
      end
      r_px     <= w_px_nxt;
      r_py     <= w_py_nxt;
      r_plot   <= w_plot_nxt;
      r_colour <= w_colour_nxt;
      if (w_touch_en) begin
        r_touched <= w_hit;
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign flag      = (r_state == S_DONE);
  assign x         = r_px[7:0];
  assign y         = r_py[6:0];
  assign colour    = r_colour;
  assign plot      = r_plot;
  assign touched   = r_touched;

endmodule

// File: tb/tb_game_draw_engine.sv
// tb_game_draw_engine: directed tests for game_draw_engine.
// Expected pixels, flags and collisions are hand-derived per scenario.
module tb_game_draw_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd7;
  logic [6:0] bird_y = 7'd0;
  logic [7:0] wall_x = 8'd0;
  logic [6:0] gap_y = 7'd0;
  logic       cmd_ready;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       flag;
  logic       touched;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_draw_engine dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .bird_y    (bird_y),
    .wall_x    (wall_x),
    .gap_y     (gap_y),
    .cmd_ready (cmd_ready),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .flag      (flag),
    .touched   (touched)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for one cycle, then scramble inputs.
  task automatic issue(
    input logic [2:0] op,
    input logic [6:0] by,
    input logic [7:0] wx,
    input logic [6:0] gy
  );
    cmd_op    = op;
    bird_y    = by;
    wall_x    = wx;
    gap_y     = gy;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    bird_y    = 7'h7f;
    wall_x    = 8'hff;
    gap_y     = 7'h7f;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || plot !== 1'b0 || flag !== 1'b0 ||
        touched !== 1'b0 || x !== 8'd0 || y !== 7'd0 ||
        colour !== 3'd0) begin
      errors++;
      $display("FAIL reset: rdy=%b plot=%b flag=%b tch=%b x=%0d y=%0d c=%b, need 1 0 0 0 0 0 000",
               cmd_ready, plot, flag, touched, x, y, colour);
    end
    reset = 1'b0;
  endtask

  task automatic test_draw_bird();
    int ex, ey;
    issue(3'd1, 7'd50, 8'd0, 7'd0);
    for (int i = 0; i < 16; i++) begin
      ex = 40 + i % 4;
      ey = 50 + i / 4;
      checks++;
      if (plot !== 1'b1 || x !== 8'(ex) || y !== 7'(ey) ||
          colour !== 3'b110 || flag !== 1'b0 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL bird_px%0d: plot=%b x=%0d y=%0d c=%b flag=%b rdy=%b, need 1 %0d %0d 110 0 0",
                 i, plot, x, y, colour, flag, cmd_ready, ex, ey);
      end
      tick();
    end
    checks++;
    if (flag !== 1'b1 || plot !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL bird_done: flag=%b plot=%b rdy=%b, need 1 0 0",
               flag, plot, cmd_ready);
    end
    tick();
    checks++;
    if (flag !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bird_idle: flag=%b rdy=%b, need 0 1", flag, cmd_ready);
    end
  endtask

  task automatic test_bird_edge();
    int ey;
    logic ep;
    issue(3'd2, 7'd118, 8'd0, 7'd0);
    for (int i = 0; i < 16; i++) begin
      ey = 118 + i / 4;
      ep = (ey <= 119);
      checks++;
      if (plot !== ep ||
          (ep && (x !== 8'(40 + i % 4) || y !== 7'(ey) ||
                  colour !== 3'b000))) begin
        errors++;
        $display("FAIL ebird_px%0d: plot=%b x=%0d y=%0d c=%b, need plot=%b x=%0d y=%0d c=000",
                 i, plot, x, y, colour, ep, 40 + i % 4, ey);
      end
      tick();
    end
    checks++;
    if (flag !== 1'b1) begin
      errors++;
      $display("FAIL ebird_done: flag=%b, need 1", flag);
    end
    tick();
  endtask

  task automatic test_draw_wall();
    int cx, cy, plots;
    logic ep;
    plots = 0;
    issue(3'd3, 7'd0, 8'd100, 7'd40);
    for (int i = 0; i < 960; i++) begin
      cx = 100 + i % 8;
      cy = i / 8;
      ep = !(cy >= 40 && cy < 72);
      if (plot === 1'b1) plots++;
      checks++;
      if (plot !== ep || flag !== 1'b0 ||
          (ep && (x !== 8'(cx) || y !== 7'(cy) ||
                  colour !== 3'b010))) begin
        errors++;
        $display("FAIL wall_px%0d: plot=%b flag=%b x=%0d y=%0d c=%b, need %b 0 %0d %0d 010",
                 i, plot, flag, x, y, colour, ep, cx, cy);
      end
      tick();
    end
    checks++;
    if (plots !== 704) begin
      errors++;
      $display("FAIL wall_count: plots=%0d, need 704", plots);
    end
    checks++;
    if (flag !== 1'b1 || plot !== 1'b0) begin
      errors++;
      $display("FAIL wall_done: flag=%b plot=%b, need 1 0", flag, plot);
    end
    tick();
  endtask

  task automatic test_wall_edge();
    int cx, cy, plots;
    logic ep;
    plots = 0;
    issue(3'd3, 7'd0, 8'd156, 7'd127);
    for (int i = 0; i < 960; i++) begin
      cx = 156 + i % 8;
      cy = i / 8;
      ep = (cx <= 159);
      if (plot === 1'b1) plots++;
      checks++;
      if (plot !== ep ||
          (ep && (x !== 8'(cx) || y !== 7'(cy)))) begin
        errors++;
        $display("FAIL wedge_px%0d: plot=%b x=%0d y=%0d, need plot=%b x=%0d y=%0d",
                 i, plot, x, y, ep, cx, cy);
      end
      tick();
    end
    checks++;
    if (plots !== 480) begin
      errors++;
      $display("FAIL wedge_count: plots=%0d, need 480", plots);
    end
    checks++;
    if (flag !== 1'b1) begin
      errors++;
      $display("FAIL wedge_done: flag=%b, need 1", flag);
    end
    tick();
  endtask

  task automatic test_clear();
    int bad;
    bad = 0;
    issue(3'd0, 7'd5, 8'd5, 7'd5);
    for (int i = 0; i < 19200; i++) begin
      checks++;
      if (plot !== 1'b1 || x !== 8'(i % 160) || y !== 7'(i / 160) ||
          colour !== 3'b000 || flag !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL clear_px%0d: plot=%b x=%0d y=%0d c=%b flag=%b, need 1 %0d %0d 000 0",
                   i, plot, x, y, colour, flag, i % 160, i / 160);
      end
      tick();
    end
    checks++;
    if (flag !== 1'b1 || plot !== 1'b0) begin
      errors++;
      $display("FAIL clear_done: flag=%b plot=%b, need 1 0", flag, plot);
    end
    tick();
  endtask

  task automatic test_check();
    logic [6:0] vby [10] = '{7'd30, 7'd50, 7'd30, 7'd30, 7'd69,
                             7'd68, 7'd118, 7'd116, 7'd30, 7'd30};
    logic [7:0] vwx [10] = '{8'd38, 8'd38, 8'd44, 8'd43, 8'd38,
                             8'd38, 8'd0, 8'd0, 8'd32, 8'd33};
    logic       vex [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                             1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      issue(3'd5, vby[i], vwx[i], 7'd40);
      checks++;
      if (plot !== 1'b0 || flag !== 1'b0 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL check%0d_run: plot=%b flag=%b rdy=%b, need 0 0 0",
                 i, plot, flag, cmd_ready);
      end
      tick();
      checks++;
      if (flag !== 1'b1 || touched !== vex[i]) begin
        errors++;
        $display("FAIL check%0d_done: flag=%b touched=%b, need 1 %b",
                 i, flag, touched, vex[i]);
      end
      tick();
    end
    issue(3'd7, 7'd0, 8'd0, 7'd0);
    tick();
    checks++;
    if (flag !== 1'b1 || touched !== 1'b1) begin
      errors++;
      $display("FAIL touched_hold: flag=%b touched=%b, need 1 1",
               flag, touched);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int bad;
    bad = 0;
    issue(3'd0, 7'd0, 8'd0, 7'd0);
    for (int i = 1; i < 500; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || plot !== 1'b0 || flag !== 1'b0 ||
        touched !== 1'b0 || x !== 8'd0 || y !== 7'd0 ||
        colour !== 3'd0) begin
      errors++;
      $display("FAIL abort: rdy=%b plot=%b flag=%b tch=%b x=%0d y=%0d c=%b, need 1 0 0 0 0 0 000",
               cmd_ready, plot, flag, touched, x, y, colour);
    end
    for (int i = 0; i < 300; i++) begin
      if (plot !== 1'b0 || flag !== 1'b0 || cmd_ready !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d active cycles, need 0", bad);
    end
    issue(3'd6, 7'd0, 8'd0, 7'd0);
    checks++;
    if (flag !== 1'b0 || plot !== 1'b0) begin
      errors++;
      $display("FAIL nop_run: flag=%b plot=%b, need 0 0", flag, plot);
    end
    tick();
    checks++;
    if (flag !== 1'b1 || plot !== 1'b0) begin
      errors++;
      $display("FAIL nop_done: flag=%b plot=%b, need 1 0", flag, plot);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic er, ef;
    cmd_op    = 3'd7;
    cmd_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      er = (k % 3 == 2);
      ef = (k % 3 == 1);
      checks++;
      if (cmd_ready !== er || flag !== ef) begin
        errors++;
        $display("FAIL b2b_cyc%0d: rdy=%b flag=%b, need %b %b",
                 k, cmd_ready, flag, er, ef);
      end
    end
    cmd_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_draw_bird();
    test_bird_edge();
    test_draw_wall();
    test_wall_edge();
    test_clear();
    test_check();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_draw_engine.md
GAME_DRAW_ENGINE -- requirements
Module: game_draw_engine

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port cmd_valid, input, 1 bit: controller presents a command.
REQ-004 SHALL have port cmd_op, input, 3 bits: 0 CLEAR, 1 DRAW_BIRD, 2 ERASE_BIRD, 3 DRAW_WALL, 4 ERASE_WALL, 5 CHECK, 6-7 NOP.
REQ-005 SHALL have port bird_y, input, 7 bits: bird top row.
REQ-006 SHALL have port wall_x, input, 8 bits: wall left column.
REQ-007 SHALL have port gap_y, input, 7 bits: top row of the wall gap.
REQ-008 SHALL have port cmd_ready, output, 1 bit: high only in IDLE.
REQ-009 SHALL have port x, output, 8 bits: pixel column to the VGA adapter.
REQ-010 SHALL have port y, output, 7 bits: pixel row to the VGA adapter.
REQ-011 SHALL have port colour, output, 3 bits: pixel colour to the VGA adapter.
REQ-012 SHALL have port plot, output, 1 bit: write enable to the VGA adapter.
REQ-013 SHALL have port flag, output, 1 bit: one-cycle done pulse.
REQ-014 SHALL have port touched, output, 1 bit: latched collision result.
REQ-015 SHALL use these constants: screen 160x120; bird 4x4 at fixed column 40; wall width 8; gap height 32.
REQ-016 SHALL use these colours: bird 3'b110, wall 3'b010, erase/clear 3'b000.

Function
REQ-017 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-018 SHALL accept a command on the cycle cmd_valid && cmd_ready is high, latching cmd_op, bird_y, wall_x and gap_y; later input changes SHALL NOT affect the command in flight.
REQ-019 SHALL emit exactly one pixel per RUN cycle, scanning x-inner and y-outer from the region origin; the first pixel SHALL appear the cycle after accept.
REQ-020 SHALL scan these regions: CLEAR 160x120 (19200 cycles); BIRD ops columns 40-43 x rows bird_y..bird_y+3 (16 cycles); WALL ops columns wall_x..wall_x+7 x rows 0-119 (960 cycles).
REQ-021 SHALL hold plot low, with the scan still consuming its cycle, for any pixel with x>159 or y>119, and for wall pixels with gap_y <= y < gap_y+32.
REQ-022 SHALL form all comparisons on widened operands (9-bit x, 8-bit y) so that wall_x+7 and gap_y+32 never wrap.
REQ-023 SHALL use a single RUN cycle for CHECK and NOP, with plot low.
REQ-024 SHALL, on CHECK, set touched = (bird columns 40-43 overlap wall_x..wall_x+7 AND (bird_y < gap_y OR bird_y+3 >= gap_y+32)) OR bird_y+3 > 119.
REQ-025 SHALL hold touched until the next CHECK completes or reset.
REQ-026 SHALL make DONE last exactly 1 cycle with flag=1 and plot=0, then return to IDLE; total latency from accept to flag = region pixel count + 1 cycles.
REQ-027 SHALL ignore cmd_valid while not in IDLE; a command held high across DONE SHALL be accepted in the following IDLE cycle, never in DONE.
REQ-028 SHALL register x, y, colour and plot so that they are stable for the whole cycle plot is high.

Reset
REQ-029 SHALL, when reset is high on any edge (including mid-RUN), force IDLE with cmd_ready=1, plot=0, flag=0, touched=0, x=0, y=0, colour=0 and counters cleared.
REQ-030 SHALL discard an aborted command after reset, producing no flag and no further plots.

Verification
REQ-031 SHALL cover: reset, then DRAW_BIRD with bird_y=50 -> 16 plots at (40..43, 50..53), colour 3'b110, flag exactly at cycle 17 after accept.
REQ-032 SHALL cover: DRAW_WALL with wall_x=100, gap_y=40 -> 960 RUN cycles, plot low for rows 40-71, 704 plots, colour 3'b010, flag at cycle 961.
REQ-033 SHALL cover: DRAW_WALL with wall_x=156 -> only columns 156-159 plotted, column 160+ plot=0, no x wrap to 0.
REQ-034 SHALL cover: CHECK with wall_x=38, gap_y=40, bird_y=30 -> touched=1; then CHECK with bird_y=50 -> touched=0; flag 2 cycles after each accept.
REQ-035 SHALL cover: CLEAR with reset asserted at RUN cycle 500 -> next cycle IDLE, plot=0, no flag; a following NOP -> flag 2 cycles after accept.
REQ-036 SHALL cover: cmd_valid held high continuously -> back-to-back accepts separated by exactly 1 DONE cycle, cmd_ready low during RUN and DONE.
